// File: rtl/iter_muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/iter_muldiv_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, cancel, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, cancel, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/iter_muldiv_sign_adj.sv
// Conditional two's-complement negate; used for operand magnitudes and result fix-up.
module muldiv_sign_adj #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);
  assign out_o = neg_i ? -in_i : in_i;
endmodule

// File: rtl/iter_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit: radix-2^MUL_STEP shift-add multiply,
// restoring divide, both sharing one 2*WIDTH+1 shift register.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 2
) (
  input logic         clk,
  input logic         reset,
  iter_muldiv_if.slave bus
);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int NMUL = WIDTH / MUL_STEP;
  localparam int AW   = WIDTH + MUL_STEP;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              div_q, qneg_q, rneg_q;
  logic [WIDTH-1:0]  opb_q;
  logic [2*WIDTH:0]  sr_q, sr_step;
  logic [WIDTH-1:0]  hi_q, lo_q, hi_d, lo_d;
  logic              done_q;

  logic              accept, last;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              a_neg, b_neg;

  // Operand magnitudes; INT_MIN negates to itself, which is the correct unsigned magnitude.
  assign a_neg = is_signed(bus.op) & bus.a[WIDTH-1];
  assign b_neg = is_signed(bus.op) & bus.b[WIDTH-1];

  muldiv_sign_adj #(.W(WIDTH)) u_abs_a (.in_i(bus.a), .neg_i(a_neg), .out_o(a_mag));
  muldiv_sign_adj #(.W(WIDTH)) u_abs_b (.in_i(bus.b), .neg_i(b_neg), .out_o(b_mag));

  assign accept = (state_q == ST_IDLE) && bus.start && !bus.cancel;
  assign last   = (state_q == ST_RUN) &&
                  (cnt_q == (div_q ? CW'(WIDTH - 1) : CW'(NMUL - 1)));

  // One iteration of the shared datapath.
  logic [AW-1:0]          mul_sum;
  logic [2*WIDTH+MUL_STEP-1:0] mul_cat;
  logic [2*WIDTH:0]       div_sh;
  logic [WIDTH:0]         div_diff;
  logic                   div_ge;

  always_comb begin
    mul_sum  = AW'(sr_q[2*WIDTH:WIDTH]) + AW'(opb_q) * AW'(sr_q[MUL_STEP-1:0]);
    mul_cat  = {mul_sum, sr_q[WIDTH-1:0]};
    div_sh   = {sr_q[2*WIDTH-1:0], 1'b0};
    div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opb_q};
    div_ge   = div_sh[2*WIDTH:WIDTH] >= {1'b0, opb_q};
    if (div_q)
      sr_step = div_ge ? {div_diff, div_sh[WIDTH-1:1], 1'b1} : div_sh;
    else
      sr_step = {1'b0, mul_cat[2*WIDTH+MUL_STEP-1:MUL_STEP]};
  end

  // Sign fix-up on the value produced by the final iteration.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  muldiv_sign_adj #(.W(2*WIDTH)) u_fix_prod (
    .in_i(sr_step[2*WIDTH-1:0]), .neg_i(qneg_q), .out_o(prod_fix));
  muldiv_sign_adj #(.W(WIDTH)) u_fix_quot (
    .in_i(sr_step[WIDTH-1:0]), .neg_i(qneg_q), .out_o(quot_fix));
  muldiv_sign_adj #(.W(WIDTH)) u_fix_rem (
    .in_i(sr_step[2*WIDTH-1:WIDTH]), .neg_i(rneg_q), .out_o(rem_fix));

  always_comb begin
    if (div_q) begin
      hi_d = rem_fix;
      lo_d = quot_fix;
    end else begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state; cancel beats both accept and completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)          state_d = ST_RUN;
      ST_RUN:  if (bus.cancel || last) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy = (state_q == ST_RUN);
  end

  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      opb_q  <= '0;
      sr_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        div_q <= is_div(bus.op);
        // Divide by zero keeps an all-ones quotient regardless of operand signs.
        qneg_q <= (a_neg ^ b_neg) & ~(is_div(bus.op) && bus.b == '0);
        rneg_q <= a_neg;
        opb_q  <= is_div(bus.op) ? b_mag : a_mag;
        sr_q   <= {{(WIDTH+1){1'b0}}, is_div(bus.op) ? a_mag : b_mag};
        cnt_q  <= '0;
      end else if (state_q == ST_RUN) begin
        if (bus.cancel) begin
          cnt_q <= '0;
        end else if (last) begin
          hi_q   <= hi_d;
          lo_q   <= lo_d;
          done_q <= 1'b1;
          cnt_q  <= '0;
          sr_q   <= sr_step;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          sr_q  <= sr_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Drives three iter_muldiv instances (MUL_STEP 1/2/4) in lockstep and checks them
// against an arithmetic reference model.
module tb_iter_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, cancel;
  logic [1:0]   op;
  logic [W-1:0] a, b;

  logic [2:0]   busy_v, done_v;
  logic [W-1:0] hi_v [3];
  logic [W-1:0] lo_v [3];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  iter_muldiv_if #(.WIDTH(W)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].start  = start;
    assign bus[g].cancel = cancel;
    assign bus[g].op     = op;
    assign bus[g].a      = a;
    assign bus[g].b      = b;
    assign busy_v[g]     = bus[g].busy;
    assign done_v[g]     = bus[g].done;
    assign hi_v[g]       = bus[g].hi;
    assign lo_v[g]       = bus[g].lo;

    iter_muldiv #(.WIDTH(W), .MUL_STEP(1 << g)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g].slave)
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy, q, r;
    sx = x;
    sy = y;
    case (o)
      OP_MULT:  return 64'(longint'(sx) * longint'(sy));
      OP_MULTU: return {32'h0, x} * {32'h0, y};
      OP_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Launch one op on all DUTs; optionally pulse start again while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input bit intrude);
    int dcnt [3];
    int dcyc [3];
    logic [63:0] res [3];
    int lat;
    for (int k = 0; k < 3; k++) begin dcnt[k] = 0; dcyc[k] = 0; res[k] = '0; end
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    for (int c = 1; c <= 36; c++) begin
      if (intrude && c == 3) begin
        start = 1'b1; op = OP_MULTU; a = 32'd1; b = 32'd1;
      end else start = 1'b0;
      @(posedge clk); #1;
      if (c == 1) chk("busy_after_accept", {61'h0, busy_v}, 64'h7);
      for (int k = 0; k < 3; k++)
        if (done_v[k]) begin
          dcnt[k]++;
          dcyc[k] = c;
          res[k]  = {hi_v[k], lo_v[k]};
        end
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lat = is_div(o) ? 32 : 32 / (1 << k);
      chk($sformatf("done_pulses[s%0d] op%0d", 1 << k, o), 64'(dcnt[k]), 64'd1);
      chk($sformatf("latency[s%0d] op%0d", 1 << k, o), 64'(dcyc[k]), 64'(lat));
      chk($sformatf("hilo[s%0d] op%0d a=%h b=%h", 1 << k, o, x, y), res[k], exp);
    end
    chk("hilo_held", {hi_v[1], lo_v[1]}, exp);
  endtask

  // Idle watch: count any done pulses over n cycles.
  task automatic quiet(input int n, output int dn);
    dn = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (done_v != 3'b0) dn++;
    end
  endtask

  initial begin
    int dn;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state[s%0d]", 1 << k),
          {busy_v[k], done_v[k], hi_v[k], lo_v[k]}, 64'h0);
    @(negedge clk); reset = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0);
    run_op(OP_MULT,  32'hFFFF_FFF9, 32'd6,         {32'hFFFF_FFFF, 32'hFFFF_FFD6}, 1'b0);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0},         1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0,         32'h8000_0000}, 1'b0);
    run_op(OP_DIVU,  32'd5,         32'd0,         {32'd5,         32'hFFFF_FFFF}, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0);
    run_op(OP_DIVU,  32'd100,       32'd7,         {32'd2,         32'd14},        1'b0);

    // Cancel a DIV at E0+5: no done, results untouched.
    @(negedge clk);
    op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cancel = (c == 5);
      @(posedge clk); #1;
      @(negedge clk);
    end
    cancel = 1'b0;
    chk("busy_after_cancel", {61'h0, busy_v}, 64'h0);
    quiet(40, dn);
    chk("no_done_after_cancel", 64'(dn), 64'd0);
    chk("hilo_after_cancel", {hi_v[0], lo_v[2]}, {32'd2, 32'd14});

    // start and cancel together while idle: not accepted.
    @(negedge clk);
    op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    chk("busy_start_cancel", {61'h0, busy_v}, 64'h0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    quiet(40, dn);
    chk("no_done_start_cancel", 64'(dn), 64'd0);
    chk("hilo_start_cancel", {hi_v[1], lo_v[1]}, {32'd2, 32'd14});

    // Reset mid-MULT.
    @(negedge clk);
    op = OP_MULT; a = 32'd12345; b = 32'd678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_midop[s%0d]", 1 << k),
          {busy_v[k], done_v[k], hi_v[k], lo_v[k]}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    quiet(40, dn);
    chk("no_done_after_reset", 64'(dn), 64'd0);

    // Random ops with corner-biased operands.
    for (int i = 0; i < 36; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'h0;
        1: rx = 32'h8000_0000;
        2: ry = 32'hFFFF_FFFF;
        3: ry = $urandom_range(1, 15);
        4: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(ro, rx, ry, model(ro, rx, ry), (i % 5) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
